// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative multiply/divide unit: latches the
// operation, runs ITER datapath steps and reports completion and exceptions.
module multdiv_ctrl #(
    parameter int unsigned ITER  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    input  logic             mult_ovf,
    output logic             busy,
    output logic             load,
    output logic             step_en,
    output logic             op_div,
    output logic [CNT_W-1:0] count,
    output logic             data_resultRDY,
    output logic             data_exception
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    logic   dz_flag;
    logic   start;

    assign start = ctrl_MULT | ctrl_DIV;

    // State, counter and strobes; each strobe is set for the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            op_div         <= 1'b0;
            dz_flag        <= 1'b0;
            busy           <= 1'b0;
            load           <= 1'b0;
            step_en        <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            load           <= 1'b0;
            step_en        <= 1'b0;
            data_resultRDY <= 1'b0;
            if (start) begin
                // Multiply wins when both pulses arrive together.
                state   <= LOAD;
                count   <= '0;
                op_div  <= ctrl_DIV & ~ctrl_MULT;
                dz_flag <= 1'b0;
                busy    <= 1'b1;
                load    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    LOAD: begin
                        count <= '0;
                        if (op_div && divisor_zero) begin
                            state          <= DONE;
                            dz_flag        <= 1'b1;
                            data_resultRDY <= 1'b1;
                        end else begin
                            state   <= RUN;
                            step_en <= 1'b1;
                        end
                    end
                    RUN: begin
                        count <= count + CNT_W'(1);
                        if (count == LAST_IDX) begin
                            state          <= DONE;
                            data_resultRDY <= 1'b1;
                        end else begin
                            step_en <= 1'b1;
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        dz_flag <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // mult_ovf is only valid during the DONE cycle, so it is gated by the registered pulse.
    assign data_exception = data_resultRDY & (dz_flag | (~op_div & mult_ovf));

endmodule
